// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
//
// Purpose:
//   Turns a character stream into cell writes for a text-mode display.
//   It tracks the cursor, interprets LF / CR / BS / FF, and blanks rows when
//   the cursor moves onto them. It also blanks the whole screen on FF, and
//   optionally after reset. Everything runs in the clk_sys domain.
//
// Parameters:
//   COLS            columns on screen (1..128)
//   ROWS            rows on screen    (1..64)
//   CLEAR_ON_RESET  1: blank the whole screen after reset release, 0: go idle
//
// Ports:
//   clk_sys   in   system clock
//   reset     in   asynchronous active-high reset
//   in_data   in   [8:0] character code from the producer
//   in_valid  in   in_data valid
//   in_ready  out  block accepts in_data this cycle (combinational)
//   char_x    out  [6:0] write column (registered)
//   char_y    out  [5:0] write row (registered)
//   char_chr  out  [8:0] write character (registered)
//   char_str  out  write strobe, one cycle per cell write (registered)
//   cur_x     out  [6:0] cursor column
//   cur_y     out  [5:0] cursor row
//   busy      out  high while a row or screen clear is running
// -----------------------------------------------------------------------------
module text_console #(
  parameter int COLS           = 80,
  parameter int ROWS           = 60,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [8:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [6:0] char_x,
  output logic [5:0] char_y,
  output logic [8:0] char_chr,
  output logic       char_str,
  output logic [6:0] cur_x,
  output logic [5:0] cur_y,
  output logic       busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  localparam logic [8:0] CODE_BS    = 9'h008;
  localparam logic [8:0] CODE_LF    = 9'h00A;
  localparam logic [8:0] CODE_FF    = 9'h00C;
  localparam logic [8:0] CODE_CR    = 9'h00D;
  localparam logic [8:0] CODE_SPACE = 9'h020;

  // ST_START exists only for the first edge after reset release, so the
  // choice between a power-up clear and idle is made once, synchronously.
  typedef enum logic [1:0] {
    ST_START        = 2'd0,
    ST_IDLE         = 2'd1,
    ST_CLEAR_ROW    = 2'd2,
    ST_CLEAR_SCREEN = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] cx_q, cx_d;          // cursor column
  logic [5:0] cy_q, cy_d;          // cursor row
  logic [6:0] clr_x_q, clr_x_d;    // clear sweep column
  logic [5:0] clr_y_q, clr_y_d;    // clear sweep row (screen clear only)
  logic [6:0] wx_q, wx_d;          // write port column
  logic [5:0] wy_q, wy_d;          // write port row
  logic [8:0] wchr_q, wchr_d;      // write port character
  logic       wstr_q, wstr_d;      // write port strobe

  logic       transfer;
  logic [5:0] next_row;

  // Reset gates in_ready directly so that the producer sees it drop in the
  // same cycle that reset rises, before any edge occurs.
  assign in_ready = (state_q == ST_IDLE) && !reset;
  assign transfer = in_valid && in_ready;

  // Line advance wraps to the top without scrolling.
  assign next_row = (cy_q == LAST_ROW) ? 6'd0 : cy_q + 6'd1;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    clr_x_d = clr_x_q;
    clr_y_d = clr_y_q;
    wx_d    = wx_q;
    wy_d    = wy_q;
    wchr_d  = wchr_q;
    wstr_d  = 1'b0;

    unique case (state_q)
      ST_START: begin
        clr_x_d = 7'd0;
        clr_y_d = 6'd0;
        state_d = CLEAR_ON_RESET ? ST_CLEAR_SCREEN : ST_IDLE;
      end

      ST_IDLE: begin
        if (transfer) begin
          unique case (in_data)
            CODE_LF: begin
              cx_d    = 7'd0;
              cy_d    = next_row;
              clr_x_d = 7'd0;
              state_d = ST_CLEAR_ROW;
            end
            CODE_CR: begin
              cx_d = 7'd0;
            end
            CODE_BS: begin
              // Backspace erases the cell it steps back onto; at column 0
              // there is nothing to erase.
              if (cx_q != 7'd0) begin
                cx_d   = cx_q - 7'd1;
                wx_d   = cx_q - 7'd1;
                wy_d   = cy_q;
                wchr_d = CODE_SPACE;
                wstr_d = 1'b1;
              end
            end
            CODE_FF: begin
              clr_x_d = 7'd0;
              clr_y_d = 6'd0;
              state_d = ST_CLEAR_SCREEN;
            end
            default: begin
              // Printable, including the whole 0x100..0x1FF range. The
              // character's own write goes out on this edge. A wrap therefore
              // blanks the next row only after the character is written.
              wx_d   = cx_q;
              wy_d   = cy_q;
              wchr_d = in_data;
              wstr_d = 1'b1;
              if (cx_q == LAST_COL) begin
                cx_d    = 7'd0;
                cy_d    = next_row;
                clr_x_d = 7'd0;
                state_d = ST_CLEAR_ROW;
              end else begin
                cx_d = cx_q + 7'd1;
              end
            end
          endcase
        end
      end

      ST_CLEAR_ROW: begin
        wx_d   = clr_x_q;
        wy_d   = cy_q;
        wchr_d = CODE_SPACE;
        wstr_d = 1'b1;
        if (clr_x_q == LAST_COL) begin
          clr_x_d = 7'd0;
          state_d = ST_IDLE;
        end else begin
          clr_x_d = clr_x_q + 7'd1;
        end
      end

      ST_CLEAR_SCREEN: begin
        wx_d   = clr_x_q;
        wy_d   = clr_y_q;
        wchr_d = CODE_SPACE;
        wstr_d = 1'b1;
        if (clr_x_q == LAST_COL) begin
          clr_x_d = 7'd0;
          if (clr_y_q == LAST_ROW) begin
            clr_y_d = 6'd0;
            cx_d    = 7'd0;
            cy_d    = 6'd0;
            state_d = ST_IDLE;
          end else begin
            clr_y_d = clr_y_q + 6'd1;
          end
        end else begin
          clr_x_d = clr_x_q + 7'd1;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_START;
      cx_q    <= 7'd0;
      cy_q    <= 6'd0;
      clr_x_q <= 7'd0;
      clr_y_q <= 6'd0;
      wx_q    <= 7'd0;
      wy_q    <= 6'd0;
      wchr_q  <= 9'd0;
      wstr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      clr_x_q <= clr_x_d;
      clr_y_q <= clr_y_d;
      wx_q    <= wx_d;
      wy_q    <= wy_d;
      wchr_q  <= wchr_d;
      wstr_q  <= wstr_d;
    end
  end

  assign char_x   = wx_q;
  assign char_y   = wy_q;
  assign char_chr = wchr_q;
  assign char_str = wstr_q;
  assign cur_x    = cx_q;
  assign cur_y    = cy_q;
  assign busy     = (state_q == ST_CLEAR_ROW) || (state_q == ST_CLEAR_SCREEN);

endmodule
